sid_spi_regs: RTL and testbench

SPI-mode-0 slave register bank that sits directly upstream of the SID voice top. It oversamples an external SPI bus with the system clock, decodes 16-bit write/read frames and drives the voice control buses: `frequency`, `duration`, `attack`, `sustain` and `waveform`. The 16-bit frequency updates atomically, so the voice never sees a half-written pitch.

---
 rtl/sid_pkg.sv | 46 ++++
 rtl/sid_sync2.sv | 31 +++
 rtl/sid_spi_regs.sv | 150 +++++++++++++++
 tb/tb_sid_spi_regs.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// ----------------------------------------------------------------------------
// sid_pkg: shared constants, FSM state type and read mux for the SID SPI bank
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sid_pkg;

  localparam int SID_FRAME_BITS = 16;

  localparam logic [2:0] SID_ADDR_FREQ_LO  = 3'd0;
  localparam logic [2:0] SID_ADDR_FREQ_HI  = 3'd1;
  localparam logic [2:0] SID_ADDR_DURATION = 3'd2;
  localparam logic [2:0] SID_ADDR_ATTACK   = 3'd3;
  localparam logic [2:0] SID_ADDR_SUSTAIN  = 3'd4;
  localparam logic [2:0] SID_ADDR_WAVEFORM = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } sid_spi_state_t;

  // Readback of the committed register state; unmapped addresses read as zero.
  function automatic logic [7:0] sid_read_mux(
    input logic [2:0]  addr,
    input logic [15:0] freq,
    input logic [7:0]  dur,
    input logic [7:0]  att,
    input logic [7:0]  sus,
    input logic [7:0]  wav
  );
    case (addr)
      SID_ADDR_FREQ_LO:  sid_read_mux = freq[7:0];
      SID_ADDR_FREQ_HI:  sid_read_mux = freq[15:8];
      SID_ADDR_DURATION: sid_read_mux = dur;
      SID_ADDR_ATTACK:   sid_read_mux = att;
      SID_ADDR_SUSTAIN:  sid_read_mux = sus;
      SID_ADDR_WAVEFORM: sid_read_mux = wav;
      default:           sid_read_mux = 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sid_sync2.sv
// ----------------------------------------------------------------------------
// sid_sync2: parameterised-depth single-bit synchronizer with a reset value port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sid_sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= {STAGES{rst_val_i}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/sid_spi_regs.sv
// ----------------------------------------------------------------------------
// sid_spi_regs: oversampled SPI mode-0 slave driving the SID voice control bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sid_spi_regs
  import sid_pkg::*;
#(
  parameter int FRAME_BITS  = SID_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] frequency,
  output logic [7:0]  duration,
  output logic [7:0]  attack,
  output logic [7:0]  sustain,
  output logic [7:0]  waveform
);

  logic sclk_s, cs_s, mosi_s;

  sid_sync2 #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .rst_val_i(1'b0), .d_i(sclk), .q_o(sclk_s));
  // Resetting cs_n low means a frame already in progress at reset release yields no falling edge.
  sid_sync2 #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .rst_val_i(1'b0), .d_i(cs_n), .q_o(cs_s));
  sid_sync2 #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .rst_val_i(1'b0), .d_i(mosi), .q_o(mosi_s));

  sid_spi_state_t        state_q, state_d;
  logic                  sclk_prev_q, cs_prev_q;
  logic [4:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [7:0]            tx_q, tx_d;
  logic                  miso_q, miso_d;
  logic [7:0]            shadow_q, shadow_d;
  logic [15:0]           freq_q, freq_d;
  logic [7:0]            dur_q, dur_d, att_q, att_d, sus_q, sus_d, wav_q, wav_d;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      shadow_q    <= '0;
      freq_q      <= '0;
      dur_q       <= '0;
      att_q       <= '0;
      sus_q       <= '0;
      wav_q       <= '0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      shadow_q    <= shadow_d;
      freq_q      <= freq_d;
      dur_q       <= dur_d;
      att_q       <= att_d;
      sus_q       <= sus_d;
      wav_q       <= wav_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    shadow_d = shadow_q;
    freq_d   = freq_q;
    dur_d    = dur_q;
    att_d    = att_q;
    sus_d    = sus_q;
    wav_d    = wav_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          cnt_d   = '0;
          sr_d    = '0;
          tx_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          sr_d = {sr_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
          // On the 8th rise sr_q[6] is the W bit and sr_q[5:3] the address.
          if (cnt_q == 5'd7 && !sr_q[6])
            tx_d = sid_read_mux(sr_q[5:3], freq_q, dur_q, att_q, sus_q, wav_q);
          if (cnt_q == 5'd15) miso_d = 1'b0;
        end else if (sclk_fall && cnt_q >= 5'd8 && cnt_q <= 5'd15) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      COMMIT: begin
        if (cnt_q == 5'd16 && sr_q[FRAME_BITS-1]) begin
          case (sr_q[14:12])
            SID_ADDR_FREQ_LO:  shadow_d = sr_q[7:0];
            SID_ADDR_FREQ_HI:  freq_d   = {sr_q[7:0], shadow_q};
            SID_ADDR_DURATION: dur_d    = sr_q[7:0];
            SID_ADDR_ATTACK:   att_d    = sr_q[7:0];
            SID_ADDR_SUSTAIN:  sus_d    = sr_q[7:0];
            SID_ADDR_WAVEFORM: wav_d    = sr_q[7:0];
            default: ;
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != SHIFT) miso_d = 1'b0;
  end

  assign miso      = miso_q;
  assign frequency = freq_q;
  assign duration  = dur_q;
  assign attack    = att_q;
  assign sustain   = sus_q;
  assign waveform  = wav_q;

endmodule

`default_nettype wire

// File: tb/tb_sid_spi_regs.sv
// ----------------------------------------------------------------------------
// tb_sid_spi_regs: table, directed and randomized checks for sid_spi_regs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sid_spi_regs;

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n, mosi, miso;
  logic [15:0] frequency;
  logic [7:0]  duration, attack, sustain, waveform;

  always #5 clk = ~clk;

  sid_spi_regs #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .frequency(frequency), .duration(duration), .attack(attack),
    .sustain(sustain), .waveform(waveform));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] f, input logic [7:0] d,
                            input logic [7:0] a, input logic [7:0] s, input logic [7:0] w);
    check({tag, " frequency"}, 32'(frequency), 32'(f));
    check({tag, " duration"},  32'(duration),  32'(d));
    check({tag, " attack"},    32'(attack),    32'(a));
    check({tag, " sustain"},   32'(sustain),   32'(s));
    check({tag, " waveform"},  32'(waveform),  32'(w));
  endtask

  // Reference model: committed bytes by address (0/1 hold the live frequency) plus the low-byte shadow.
  logic [7:0] m_reg [8];
  logic [7:0] m_shadow;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_shadow = 8'h00;
  endfunction

  function automatic logic [7:0] m_frame(input logic [16:0] w, input int n);
    logic [7:0] hdr, rd;
    int         a;
    hdr = 8'(w >> (n - 8));
    a   = int'(hdr[6:4]);
    rd  = 8'h00;
    if (!hdr[7]) rd = (a < 6) ? m_reg[a] : 8'h00;
    if (n == 16 && w[15]) begin
      a = int'(w[14:12]);
      if (a == 0) m_shadow = w[7:0];
      else if (a == 1) begin
        m_reg[1] = w[7:0];
        m_reg[0] = m_shadow;
      end else if (a < 6) m_reg[a] = w[7:0];
    end
    return rd;
  endfunction

  // Shifts n bits MSB first with cs_n left low; rd collects miso at rises 9..16.
  task automatic spi_bits(input logic [16:0] w, input int n, output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk) cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi = w[n-1-i];
      repeat (5) @(negedge clk);
      if (i >= 8 && i < 16) rd[15-i] = miso;
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_release();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [16:0] word;
    int          nbits;
    logic [15:0] e_freq;
    logic [7:0]  e_dur, e_att, e_sus, e_wav;
    logic        chk_rd;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t        vec [14];
  logic [7:0]  rd, exp_rd;
  logic [16:0] rw;
  int          rn;

  initial begin
    vec[0]  = '{17'h0A0A5, 16, 16'h1234, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    vec[1]  = '{17'h0B00F, 16, 16'h1234, 8'hA5, 8'h0F, 8'h00, 8'h00, 1'b0, 8'h00};
    vec[2]  = '{17'h0C0C3, 16, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h00, 1'b0, 8'h00};
    vec[3]  = '{17'h0D040, 16, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h40, 1'b0, 8'h00};
    vec[4]  = '{17'h0F0EE, 16, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h40, 1'b0, 8'h00};
    vec[5]  = '{17'h0E0EE, 16, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h40, 1'b0, 8'h00};
    vec[6]  = '{17'h03000, 16, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h40, 1'b1, 8'h0F};
    vec[7]  = '{17'h06000, 16, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h40, 1'b1, 8'h00};
    vec[8]  = '{17'h0687F, 15, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h40, 1'b0, 8'h00};
    vec[9]  = '{17'h1A1FF, 17, 16'h1234, 8'hA5, 8'h0F, 8'hC3, 8'h40, 1'b0, 8'h00};
    vec[10] = '{17'h0AF5A, 16, 16'h1234, 8'h5A, 8'h0F, 8'hC3, 8'h40, 1'b0, 8'h00};
    vec[11] = '{17'h08099, 16, 16'h1234, 8'h5A, 8'h0F, 8'hC3, 8'h40, 1'b0, 8'h00};
    vec[12] = '{17'h00000, 16, 16'h1234, 8'h5A, 8'h0F, 8'hC3, 8'h40, 1'b1, 8'h34};
    vec[13] = '{17'h01000, 16, 16'h1234, 8'h5A, 8'h0F, 8'hC3, 8'h40, 1'b1, 8'h12};

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_outs("reset", 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset miso", 32'(miso), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // FREQ_LO lands in the shadow only; FREQ_HI commits exactly 4 clk after the cs_n rise.
    spi_bits(17'h08034, 16, rd);
    cs_release();
    void'(m_frame(17'h08034, 16));
    check("freq_lo no commit", 32'(frequency), 32'h0000);
    spi_bits(17'h09012, 16, rd);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("freq 3clk after cs rise", 32'(frequency), 32'h0000);
    @(negedge clk);
    check("freq 4clk after cs rise", 32'(frequency), 32'h1234);
    repeat (4) @(negedge clk);
    void'(m_frame(17'h09012, 16));

    for (int i = 0; i < 14; i++) begin
      spi_bits(vec[i].word, vec[i].nbits, rd);
      cs_release();
      void'(m_frame(vec[i].word, vec[i].nbits));
      check_outs($sformatf("vec%0d", i), vec[i].e_freq, vec[i].e_dur, vec[i].e_att,
                 vec[i].e_sus, vec[i].e_wav);
      if (vec[i].chk_rd) check($sformatf("vec%0d readback", i), 32'(rd), 32'(vec[i].e_rd));
    end

    for (int i = 0; i < 30; i++) begin
      rw = 17'($urandom);
      case ($urandom_range(0, 4))
        0:       rn = 15;
        1:       rn = 17;
        default: rn = 16;
      endcase
      spi_bits(rw, rn, rd);
      cs_release();
      exp_rd = m_frame(rw, rn);
      if (rn >= 16) check($sformatf("rand%0d miso", i), 32'(rd), 32'(exp_rd));
      check_outs($sformatf("rand%0d", i), {m_reg[1], m_reg[0]}, m_reg[2], m_reg[3],
                 m_reg[4], m_reg[5]);
    end
    check("miso idle", 32'(miso), 32'h0);

    // Reset with a write frame half shifted and cs_n still low: frame lost, outputs clear.
    spi_bits(17'h00281, 10, rd);
    rst_n = 1'b0;
    @(negedge clk);
    check_outs("mid-frame reset", 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cs_release();
    m_reset();
    check_outs("after mid-frame reset", 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_bits(17'h0A077, 16, rd);
    cs_release();
    void'(m_frame(17'h0A077, 16));
    check_outs("frame after reset", 16'h0000, 8'h77, 8'h00, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
